// File: rtl/add_sub_rr_scheduler.sv
// Round-robin scheduler that time-shares one N-bit add/sub datapath between
// NUM_REQ requesters. The winner's operands are captured at grant. The result
// is computed one cycle later and held under a valid/ready handshake until the
// consumer accepts it.

// Combinational N-bit add/sub. Bit N of the extended result is the carry for
// add, or the borrow (a < b) for sub.
module add_sub_unit #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] res_o,
  output logic         carry_o
);
  logic [N:0] ext;

  // Zero-extend both operands so that bit N carries the carry or borrow.
  always_comb begin
    if (sub_i) ext = {1'b0, a_i} - {1'b0, b_i};
    else       ext = {1'b0, a_i} + {1'b0, b_i};
  end

  assign res_o   = ext[N-1:0];
  assign carry_o = ext[N];
endmodule

module add_sub_rr_scheduler #(
  parameter int N       = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_in,
  input  logic [NUM_REQ*N-1:0] a_bus_in,
  input  logic [NUM_REQ*N-1:0] b_bus_in,
  input  logic [NUM_REQ-1:0]   opcode_in,
  output logic [NUM_REQ-1:0]   gnt_out,
  output logic [N-1:0]         result_out,
  output logic                 carry_out,
  output logic [ID_W-1:0]      result_id_out,
  output logic                 result_valid_out,
  input  logic                 result_ready_in,
  output logic                 busy_out
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_gnt_q, last_gnt_d;

  // Operands captured at grant time.
  logic [N-1:0]    a_q, b_q;
  logic            op_q;
  logic [ID_W-1:0] id_q;

  // Result registers. They keep their value after valid drops.
  logic [N-1:0]    result_q;
  logic            carry_q;
  logic [ID_W-1:0] rid_q;
  logic            valid_q, valid_d;

  logic            found;
  logic [ID_W-1:0] win;
  logic [N-1:0]    a_sel, b_sel;
  logic            op_sel;
  logic [NUM_REQ-1:0] gnt;
  logic            load, capture;
  logic [N-1:0]    alu_res;
  logic            alu_carry;

  // Cyclic search starting just after the last grant. The last granted
  // requester is therefore checked last and has the lowest priority.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_gnt_q) + k) % NUM_REQ;
      if (!found && req_in[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Select the winner's operand slices.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        a_sel  = a_bus_in[i*N +: N];
        b_sel  = b_bus_in[i*N +: N];
        op_sel = opcode_in[i];
      end
    end
  end

  // Next-state logic and control strobes. The grant is combinational in IDLE
  // so that it coincides with the edge that latches the operands. Reset
  // gates the grant so that no pulse is seen while rst_n is low.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    valid_d    = valid_q;
    gnt        = '0;
    load       = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && rst_n) begin
          gnt[win] = 1'b1;
          load     = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (result_ready_in) begin
          valid_d    = 1'b0;
          last_gnt_d = id_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, arbitration pointer and valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= ID_W'(NUM_REQ - 1);
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      valid_q    <= valid_d;
    end
  end

  // Operand capture at grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 1'b0;
      id_q <= '0;
    end else if (load) begin
      a_q  <= a_sel;
      b_q  <= b_sel;
      op_q <= op_sel;
      id_q <= win;
    end
  end

  add_sub_unit #(.N(N)) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .sub_i   (op_q),
    .res_o   (alu_res),
    .carry_o (alu_carry)
  );

  // Result registers are loaded only on the EXEC exit edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      rid_q    <= '0;
    end else if (capture) begin
      result_q <= alu_res;
      carry_q  <= alu_carry;
      rid_q    <= id_q;
    end
  end

  assign gnt_out          = gnt;
  assign result_out       = result_q;
  assign carry_out        = carry_q;
  assign result_id_out    = rid_q;
  assign result_valid_out = valid_q;
  assign busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_add_sub_rr_scheduler.sv
// Directed bench for add_sub_rr_scheduler. Inputs are driven and outputs are
// sampled just after the falling edge.
module tb_add_sub_rr_scheduler;
  localparam int N = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_in;
  logic [NR*N-1:0] a_bus_in, b_bus_in;
  logic [NR-1:0]   opcode_in;
  logic [NR-1:0]   gnt_out;
  logic [N-1:0]    result_out;
  logic            carry_out;
  logic [IW-1:0]   result_id_out;
  logic            result_valid_out;
  logic            result_ready_in;
  logic            busy_out;

  int errors = 0;
  int checks = 0;

  add_sub_rr_scheduler #(.N(N), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_in           (req_in),
    .a_bus_in         (a_bus_in),
    .b_bus_in         (b_bus_in),
    .opcode_in        (opcode_in),
    .gnt_out          (gnt_out),
    .result_out       (result_out),
    .carry_out        (carry_out),
    .result_id_out    (result_id_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .busy_out         (busy_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = 4'hF; result_ready_in = 1'b0; opcode_in = '0;
    a_bus_in = '0; b_bus_in = '0;
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      checks++;
      if ({gnt_out, result_out, carry_out, result_id_out, result_valid_out, busy_out} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: gnt=%b res=%h c=%b id=%0d v=%b busy=%b want all 0",
                 c, gnt_out, result_out, carry_out, result_id_out, result_valid_out, busy_out);
      end
    end
    rst_n = 1'b1; #1;
    checks++;
    if (gnt_out !== 4'b0001) begin
      errors++; $display("FAIL reset_first_gnt: got %b want 0001", gnt_out);
    end
    step(); req_in = '0; result_ready_in = 1'b1; #1;
    checks++;
    if (busy_out !== 1'b1 || result_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_exec: busy=%b valid=%b want 1/0", busy_out, result_valid_out);
    end
    step(); #1;
    checks++;
    if (result_valid_out !== 1'b1 || result_id_out !== 2'd0 || result_out !== 16'h0000) begin
      errors++; $display("FAIL reset_first_result: v=%b id=%0d res=%h want 1/0/0000",
                         result_valid_out, result_id_out, result_out);
    end
    step(); #1;
    checks++;
    if (result_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL reset_drain: v=%b busy=%b want 0/0", result_valid_out, busy_out);
    end
  endtask

  task automatic test_single_add();
    step();
    req_in = 4'b0100; a_bus_in[2*N +: N] = 16'h1234; b_bus_in[2*N +: N] = 16'h0001;
    opcode_in = 4'b0000; #1;
    checks++;
    if (gnt_out !== 4'b0100) begin
      errors++; $display("FAIL add_gnt: got %b want 0100", gnt_out);
    end
    step(); req_in = '0; #1;
    checks++;
    if (gnt_out !== 4'b0000 || result_valid_out !== 1'b0) begin
      errors++; $display("FAIL add_exec: gnt=%b v=%b want 0000/0", gnt_out, result_valid_out);
    end
    step(); #1;
    checks++;
    if (result_out !== 16'h1235 || carry_out !== 1'b0 || result_id_out !== 2'd2 || result_valid_out !== 1'b1) begin
      errors++; $display("FAIL add_result: res=%h c=%b id=%0d v=%b want 1235/0/2/1",
                         result_out, carry_out, result_id_out, result_valid_out);
    end
    step(); #1;
    checks++;
    if (result_valid_out !== 1'b0 || result_out !== 16'h1235 || result_id_out !== 2'd2) begin
      errors++; $display("FAIL add_retain: v=%b res=%h id=%0d want 0/1235/2",
                         result_valid_out, result_out, result_id_out);
    end
  endtask

  task automatic test_carry_borrow();
    logic [N-1:0] va, vb, er;
    logic         vo, ec;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       begin va = 16'hFFFF; vb = 16'h0001; vo = 1'b0; er = 16'h0000; ec = 1'b1; end
        1:       begin va = 16'h0005; vb = 16'h0007; vo = 1'b1; er = 16'hFFFE; ec = 1'b1; end
        default: begin va = 16'h0007; vb = 16'h0005; vo = 1'b1; er = 16'h0002; ec = 1'b0; end
      endcase
      step();
      req_in = 4'b0010; a_bus_in[N +: N] = va; b_bus_in[N +: N] = vb; opcode_in = {2'b00, vo, 1'b0}; #1;
      checks++;
      if (gnt_out !== 4'b0010) begin
        errors++; $display("FAIL carry_gnt t%0d: got %b want 0010", t, gnt_out);
      end
      step(); req_in = '0;
      step(); #1;
      checks++;
      if (result_out !== er || carry_out !== ec || result_id_out !== 2'd1 || result_valid_out !== 1'b1) begin
        errors++; $display("FAIL carry_result t%0d: res=%h c=%b id=%0d v=%b want %h/%b/1/1",
                           t, result_out, carry_out, result_id_out, result_valid_out, er, ec);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] eg;
    logic [N-1:0]  er;
    int            e;
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; req_in = 4'hF; result_ready_in = 1'b1; opcode_in = '0;
    for (int i = 0; i < NR; i++) begin
      a_bus_in[i*N +: N] = 16'h1000 * 16'(i + 1);
      b_bus_in[i*N +: N] = 16'(i + 1);
    end
    for (int k = 0; k < 5; k++) begin
      e  = k % NR;
      eg = 4'b0001 << e;
      er = 16'h1000 * 16'(e + 1) + 16'(e + 1);
      #1;
      checks++;
      if (gnt_out !== eg) begin
        errors++; $display("FAIL rr_gnt k%0d: got %b want %b", k, gnt_out, eg);
      end
      step(); #1;
      checks++;
      if (gnt_out !== 4'b0000) begin
        errors++; $display("FAIL rr_exec_gnt k%0d: got %b want 0000", k, gnt_out);
      end
      step(); #1;
      checks++;
      if (result_valid_out !== 1'b1 || result_id_out !== IW'(e) || result_out !== er) begin
        errors++; $display("FAIL rr_result k%0d: v=%b id=%0d res=%h want 1/%0d/%h",
                           k, result_valid_out, result_id_out, result_out, e, er);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    result_ready_in = 1'b0; #1;
    checks++;
    if (gnt_out !== 4'b0010) begin
      errors++; $display("FAIL bp_gnt: got %b want 0010", gnt_out);
    end
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (result_valid_out !== 1'b1 || result_id_out !== 2'd1 || result_out !== 16'h2002 ||
          gnt_out !== 4'b0000 || busy_out !== 1'b1) begin
        errors++; $display("FAIL bp_hold c%0d: v=%b id=%0d res=%h gnt=%b busy=%b want 1/1/2002/0000/1",
                           c, result_valid_out, result_id_out, result_out, gnt_out, busy_out);
      end
      result_ready_in = (c == 4);
      step();
    end
    result_ready_in = 1'b0; #1;
    checks++;
    if (result_valid_out !== 1'b0 || gnt_out !== 4'b0100) begin
      errors++; $display("FAIL bp_release: v=%b gnt=%b want 0/0100", result_valid_out, gnt_out);
    end
    step(); req_in = '0; result_ready_in = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    step(); req_in = 4'b0010; result_ready_in = 1'b0; #1;
    checks++;
    if (gnt_out !== 4'b0010) begin
      errors++; $display("FAIL mid_gnt: got %b want 0010", gnt_out);
    end
    step(); rst_n = 1'b0; req_in = '0;
    step(); #1;
    checks++;
    if ({result_valid_out, busy_out, result_out, carry_out, result_id_out} !== '0) begin
      errors++; $display("FAIL mid_exec_reset: v=%b busy=%b res=%h want 0/0/0000",
                         result_valid_out, busy_out, result_out);
    end
    rst_n = 1'b1; req_in = 4'hF; #1;
    checks++;
    if (gnt_out !== 4'b0001) begin
      errors++; $display("FAIL mid_exec_regnt: got %b want 0001", gnt_out);
    end
    step(); req_in = '0; result_ready_in = 1'b1;
    step(); #1;
    checks++;
    if (result_valid_out !== 1'b1 || result_id_out !== 2'd0) begin
      errors++; $display("FAIL mid_op0: v=%b id=%0d want 1/0", result_valid_out, result_id_out);
    end
    step(); req_in = 4'hF; result_ready_in = 1'b0; #1;
    checks++;
    if (gnt_out !== 4'b0010) begin
      errors++; $display("FAIL mid_gnt1: got %b want 0010", gnt_out);
    end
    step(); req_in = '0;
    step(); #1;
    checks++;
    if (result_valid_out !== 1'b1 || result_id_out !== 2'd1) begin
      errors++; $display("FAIL mid_hold: v=%b id=%0d want 1/1", result_valid_out, result_id_out);
    end
    rst_n = 1'b0;
    step(); #1;
    checks++;
    if ({result_valid_out, busy_out, result_out, carry_out, result_id_out} !== '0) begin
      errors++; $display("FAIL mid_hold_reset: v=%b busy=%b res=%h id=%0d want 0/0/0000/0",
                         result_valid_out, busy_out, result_out, result_id_out);
    end
    rst_n = 1'b1; req_in = 4'hF; #1;
    checks++;
    if (gnt_out !== 4'b0001) begin
      errors++; $display("FAIL mid_hold_regnt: got %b want 0001", gnt_out);
    end
    step(); req_in = '0; result_ready_in = 1'b1;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_carry_borrow();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
